// File: rtl/video_capture_ring.sv
// Raster capture stage: writes the capture window of each frame into a
// multi-line RAM ring, with optional 2:1 horizontal averaging and 240p field mode.
module video_capture_ring #(
  parameter int COLOR_W         = 8,
  parameter int ADDR_W          = 15,
  parameter int H_CAPTURE_START = 0,
  parameter int H_CAPTURE_END   = 640,
  parameter int V_CAPTURE_START = 0,
  parameter int V_CAPTURE_END   = 480,
  parameter int LD_FIELD1_END   = 240,
  parameter int LD_FIELD2_START = 263,
  parameter int LD_FIELD2_END   = 503,
  parameter int RING_LINES      = 32,
  parameter int TRIGGER_LINE    = 5,
  localparam int SLOT_W         = $clog2(RING_LINES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COLOR_W-1:0]     R,
  input  logic [COLOR_W-1:0]     G,
  input  logic [COLOR_W-1:0]     B,
  input  logic [11:0]            counterX,
  input  logic [11:0]            counterY,
  input  logic                   line_doubler,
  input  logic                   hdiv2,
  output logic [3*COLOR_W-1:0]   wrdata,
  output logic [ADDR_W-1:0]      wraddr,
  output logic                   wren,
  output logic                   starttrigger,
  output logic [SLOT_W-1:0]      slot,
  output logic                   state_dbg
);

  localparam int LINE_WORDS = H_CAPTURE_END - H_CAPTURE_START;
  localparam int CNT_W      = $clog2(TRIGGER_LINE + 1);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    CAPTURE    = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                ld_q, hd_q, ld_eff, hd_eff;
  logic                frame_start, cap_en;
  logic [12:0]         x_off, y_off, y_f2;
  logic [11:0]         xr;
  logic                h_in, v_norm, v_ld, v_in, in_win, line_end, do_write;
  logic [ADDR_W-1:0]   base_q, base_eff;
  logic [CNT_W-1:0]    cnt_q;
  logic                armed_q, fire;
  logic [COLOR_W-1:0]  lat_r, lat_g, lat_b;
  logic [COLOR_W-1:0]  avg_r, avg_g, avg_b;

  assign frame_start = (counterX == 12'd0) && (counterY == 12'd0);
  assign state_dbg   = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  // The frame-start pixel itself is captured, so WAIT_FRAME enables capture on (0,0).
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d = CAPTURE;
          cap_en  = 1'b1;
        end
      end
      CAPTURE: cap_en = 1'b1;
      default: state_d = WAIT_FRAME;
    endcase
  end

  // Modes take their new value on the frame-start pixel, then hold for the frame.
  assign ld_eff = frame_start ? line_doubler : ld_q;
  assign hd_eff = frame_start ? hdiv2 : hd_q;

  // Window tests use a borrow bit so a zero start offset needs no special case.
  assign x_off  = {1'b0, counterX} - 13'(H_CAPTURE_START);
  assign xr     = x_off[11:0];
  assign h_in   = !x_off[12] && (x_off[11:0] < 12'(LINE_WORDS));
  assign y_off  = {1'b0, counterY} - 13'(V_CAPTURE_START);
  assign v_norm = !y_off[12] && (y_off[11:0] < 12'(V_CAPTURE_END - V_CAPTURE_START));
  assign y_f2   = {1'b0, counterY} - 13'(LD_FIELD2_START);
  assign v_ld   = (counterY < 12'(LD_FIELD1_END)) ||
                  (!y_f2[12] && (y_f2[11:0] < 12'(LD_FIELD2_END - LD_FIELD2_START)));
  assign v_in   = ld_eff ? v_ld : v_norm;

  assign in_win   = cap_en && h_in && v_in;
  assign line_end = in_win && (xr == 12'(LINE_WORDS - 1));
  assign do_write = in_win && (!hd_eff || xr[0]);
  assign base_eff = frame_start ? '0 : base_q;
  assign fire     = armed_q && (cnt_q == CNT_W'(TRIGGER_LINE));

  assign avg_r = COLOR_W'(({1'b0, lat_r} + {1'b0, R}) >> 1);
  assign avg_g = COLOR_W'(({1'b0, lat_g} + {1'b0, G}) >> 1);
  assign avg_b = COLOR_W'(({1'b0, lat_b} + {1'b0, B}) >> 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_q         <= 1'b0;
      hd_q         <= 1'b0;
      wren         <= 1'b0;
      wraddr       <= '0;
      wrdata       <= '0;
      lat_r        <= '0;
      lat_g        <= '0;
      lat_b        <= '0;
      starttrigger <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      slot         <= '0;
      base_q       <= '0;
    end else begin
      if (frame_start) begin
        ld_q <= line_doubler;
        hd_q <= hdiv2;
      end

      wren <= do_write;
      if (do_write) begin
        wraddr <= base_eff + (hd_eff ? ADDR_W'(xr >> 1) : ADDR_W'(xr));
        wrdata <= hd_eff ? {avg_r, avg_g, avg_b} : {R, G, B};
      end
      if (in_win && hd_eff && !xr[0]) begin
        lat_r <= R;
        lat_g <= G;
        lat_b <= B;
      end

      starttrigger <= fire;
      if (frame_start)  armed_q <= 1'b1;
      else if (fire)    armed_q <= 1'b0;

      // A frame start outranks a coincident line end.
      if (frame_start) begin
        slot   <= '0;
        base_q <= '0;
        cnt_q  <= '0;
      end else if (line_end) begin
        if (slot == SLOT_W'(RING_LINES - 1)) begin
          slot   <= '0;
          base_q <= '0;
        end else begin
          slot   <= slot + SLOT_W'(1);
          base_q <= base_q + ADDR_W'(LINE_WORDS);
        end
        if (cnt_q != CNT_W'(TRIGGER_LINE)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_capture_ring.sv
// Bench for video_capture_ring: a frame-level model predicts every output each
// cycle, with literal spot values pinning the model at known pixels.
module tb_video_capture_ring;

  localparam int LW     = 640;
  localparam int HS     = 0;
  localparam int HE     = 640;
  localparam int VS     = 0;
  localparam int VE     = 480;
  localparam int LD1    = 240;
  localparam int LD2S   = 263;
  localparam int LD2E   = 503;
  localparam int RING   = 32;
  localparam int TRIG   = 5;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]  R, G, B;
  logic [11:0] counterX, counterY;
  logic        line_doubler, hdiv2;
  logic [23:0] wrdata;
  logic [14:0] wraddr;
  logic        wren, starttrigger, state_dbg;
  logic [4:0]  slot;

  video_capture_ring dut (
    .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
    .counterX(counterX), .counterY(counterY),
    .line_doubler(line_doubler), .hdiv2(hdiv2),
    .wrdata(wrdata), .wraddr(wraddr), .wren(wren),
    .starttrigger(starttrigger), .slot(slot), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int trig_seen = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // model: frame-level view of the capture rules
  logic [38:0] exp_q[$];
  int   m_in_frame, m_ld, m_hd, m_slot, m_cnt, m_armed;
  int   m_lr, m_lg, m_lb;
  logic exp_wren, exp_trig;
  int   exp_slot;

  always @(posedge clock or negedge reset) begin
    int x, y, xr, a, pr, pg, pb;
    bit fs, hin, vin, fire_now;
    if (!reset) begin
      m_in_frame = 0; m_ld = 0; m_hd = 0; m_slot = 0; m_cnt = 0; m_armed = 0;
      m_lr = 0; m_lg = 0; m_lb = 0;
      exp_wren = 0; exp_trig = 0; exp_slot = 0;
      exp_q.delete();
    end else begin
      x = counterX; y = counterY;
      fs = (x == 0 && y == 0);
      fire_now = (m_armed != 0) && (m_cnt == TRIG);
      exp_trig = fire_now;
      if (fire_now) m_armed = 0;
      if (fs) begin
        m_in_frame = 1; m_ld = line_doubler; m_hd = hdiv2;
        m_slot = 0; m_cnt = 0; m_armed = 1;
      end
      hin = (x >= HS) && (x < HE);
      xr  = x - HS;
      vin = m_ld ? ((y < LD1) || (y >= LD2S && y < LD2E)) : (y >= VS && y < VE);
      exp_wren = 0;
      if (m_in_frame != 0 && hin && vin) begin
        if (m_hd == 0) begin
          a = m_slot * LW + xr;
          exp_q.push_back({15'(a), R, G, B});
          exp_wren = 1;
        end else if (xr % 2 == 0) begin
          m_lr = R; m_lg = G; m_lb = B;
        end else begin
          a  = m_slot * LW + xr / 2;
          pr = (m_lr + R) / 2; pg = (m_lg + G) / 2; pb = (m_lb + B) / 2;
          exp_q.push_back({15'(a), 8'(pr), 8'(pg), 8'(pb)});
          exp_wren = 1;
        end
        if (xr == LW - 1 && !fs) begin
          m_slot = (m_slot + 1) % RING;
          if (m_cnt < TRIG) m_cnt = m_cnt + 1;
        end
      end
      exp_slot = m_slot;
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clock) begin
    logic [38:0] e;
    if (reset) begin
      chk("wren", wren, exp_wren);
      chk("starttrigger", starttrigger, exp_trig);
      chk("slot", slot, exp_slot);
      if (starttrigger) trig_seen++;
      if (wren) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wraddr", wraddr, e[38:24]);
          chk("wrdata", wrdata, e[23:0]);
        end
      end
    end
  end

  // driver: inputs change on the falling edge, return one cycle later
  task automatic drive(input int x, input int y, input logic [7:0] r, g, b);
    counterX = 12'(x); counterY = 12'(y);
    R = r; G = g; B = b;
    @(negedge clock);
  endtask

  int xs[10] = '{0, 1, 5, 7, 636, 637, 638, 639, 640, 799};

  task automatic run_frame(input int fno, input logic ld, input logic hd);
    int x;
    logic [7:0] r, g, b;
    bit trig_pend;
    trig_pend = 0;
    line_doubler = ld; hdiv2 = hd; trig_seen = 0;
    for (int y = 0; y < 525; y++) begin
      if (fno == 2 && y == 100) line_doubler = ~ld;
      for (int k = 0; k < 10; k++) begin
        x = xs[k];
        r = 8'(x * 7 + y); g = 8'(x + y * 3); b = 8'(x ^ y);
        if (fno == 0 && x == 5 && y == 3) begin r = 8'h12; g = 8'h34; b = 8'h56; end
        if (fno == 1 && y == 0 && x == 0) r = 8'h10;
        if (fno == 1 && y == 0 && x == 1) r = 8'h21;
        drive(x, y, r, g, b);
        if (trig_pend) chk("pin_trigger_pulse", starttrigger, 1);
        trig_pend = (fno == 0 && x == 639 && y == 4);
        if (trig_pend) chk("pin_trigger_not_yet", starttrigger, 0);
        if (fno == 0 && x == 0 && y == 0) begin
          chk("pin_first_wren", wren, 1);
          chk("pin_first_addr", wraddr, 0);
        end
        if (fno == 0 && x == 5 && y == 3) begin
          chk("pin_addr_5_3", wraddr, 1925);
          chk("pin_data_5_3", wrdata, 24'h123456);
        end
        if (fno == 0 && x == 639 && y == 31) chk("pin_addr_last_slot", wraddr, 20479);
        if (fno == 0 && x == 7 && y == 32) begin
          chk("pin_addr_wrap", wraddr, 7);
          chk("pin_slot_wrap", slot, 0);
        end
        if (fno == 1 && x == 0 && y == 0) chk("pin_hdiv_even_nowr", wren, 0);
        if (fno == 1 && x == 1 && y == 0) begin
          chk("pin_hdiv_wren", wren, 1);
          chk("pin_hdiv_addr", wraddr, 0);
          chk("pin_hdiv_red", wrdata[23:16], 8'h18);
        end
        if (fno == 2 && x == 0 && y == 239) begin
          chk("pin_ld_addr_239", wraddr, 9600);
          chk("pin_ld_slot_239", slot, 15);
        end
        if (fno == 2 && x == 0 && y == 250) chk("pin_ld_gap_nowr", wren, 0);
        if (fno == 2 && x == 0 && y == 263) begin
          chk("pin_ld_addr_263", wraddr, 10240);
          chk("pin_ld_slot_263", slot, 16);
        end
        if (fno == 3 && x == 0 && y == 250) begin
          chk("pin_normal_again_wren", wren, 1);
          chk("pin_normal_again_addr", wraddr, 16640);
        end
      end
    end
    chk("pin_one_trigger_per_frame", trig_seen, 1);
  endtask

  initial begin
    R = '0; G = '0; B = '0; counterX = '0; counterY = '0;
    line_doubler = 1'b0; hdiv2 = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) drive(100, 50, 8'h11, 8'h22, 8'h33);
    chk("pin_reset_wren", wren, 0);
    chk("pin_reset_wraddr", wraddr, 0);
    chk("pin_reset_slot", slot, 0);
    chk("pin_reset_state", state_dbg, 0);
    reset = 1'b1;
    drive(100, 50, 8'h44, 8'h55, 8'h66);
    chk("pin_midframe_nowr", wren, 0);
    for (int y = 50; y < 53; y++)
      for (int k = 0; k < 10; k++) drive(xs[k], y, 8'(k), 8'(y), 8'h5a);
    chk("pin_midframe_waiting", state_dbg, 0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b1);
    run_frame(2, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(799, 600, 8'h00, 8'h00, 8'h00);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_capture_ring.md
Name: video_capture_ring

Overview:
- Parametrised successor to the video2ram capture stage.
- Takes incoming pixels with their raster counters and writes the capture window into a multi-line ring buffer in dual-port RAM.
- Adds configurable ring depth, 2:1 horizontal averaging and frame-aligned mode latching.
- Emits a once-per-frame start trigger for the output-side reader (ram2video via Flag_CrossDomain).

Parameters:
- COLOR_W, 8, bits per colour channel; wrdata is 3*COLOR_W.
- ADDR_W, 15, RAM address width.
- H_CAPTURE_START, 0, first captured counterX.
- H_CAPTURE_END, 640, first non-captured counterX; LINE_WORDS = H_CAPTURE_END - H_CAPTURE_START.
- V_CAPTURE_START, 0, first captured line (normal mode).
- V_CAPTURE_END, 480, first non-captured line (normal mode).
- LD_FIELD1_END, 240, line-doubler mode: lines below this are captured.
- LD_FIELD2_START, 263, line-doubler mode: second-field capture begins.
- LD_FIELD2_END, 503, line-doubler mode: second-field capture ends (exclusive).
- RING_LINES, 32, line slots in the ring. RING_LINES*LINE_WORDS <= 2^ADDR_W.
- TRIGGER_LINE, 5, captured-line count at which starttrigger fires.

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- R, G, B  in  COLOR_W each  pixel colour
- counterX  in  12  horizontal raster position
- counterY  in  12  vertical raster position
- line_doubler  in  1  mode request: 240p field capture
- hdiv2  in  1  mode request: 2:1 horizontal averaging
- wrdata  out  3*COLOR_W  {R,G,B} to RAM
- wraddr  out  ADDR_W  RAM write address
- wren  out  1  RAM write enable
- starttrigger  out  1  one-cycle pulse per frame
- slot  out  clog2(RING_LINES)  current ring line slot

Behaviour:
- Reset (reset=0, asynchronous) clears all state and outputs:
  - wrdata=0, wraddr=0, wren=0, starttrigger=0, slot=0.
  - FSM enters WAIT_FRAME; latched modes = 0.
- FSM:
  - WAIT_FRAME: no writes. On counterX==0 && counterY==0, go to CAPTURE. Latch line_doubler and hdiv2, clear slot and line count, re-arm the trigger.
  - CAPTURE: writes per the window. Each later frame start (0,0) re-latches modes, clears slot and line count, and re-arms the trigger; the FSM stays in CAPTURE.
- Mode inputs are used only in their latched form. Mid-frame changes take effect at the next frame start.
- Vertical capture:
  - Normal mode: V_CAPTURE_START <= y < V_CAPTURE_END.
  - Line-doubler mode: y < LD_FIELD1_END, or LD_FIELD2_START <= y < LD_FIELD2_END.
- Horizontal capture: H_CAPTURE_START <= x < H_CAPTURE_END. xr = x - H_CAPTURE_START.
- Latency: all outputs are registered. Inputs sampled in cycle n appear on wrdata/wraddr/wren in cycle n+1.
- hdiv2=0:
  - Every captured pixel gives wren=1, wrdata={R,G,B}, wraddr = slot*LINE_WORDS + xr.
- hdiv2=1:
  - Even xr: latch the pixel; no write.
  - Odd xr: wren=1, each channel = (latched + current) >> 1 computed at COLOR_W+1 bits, wraddr = slot*LINE_WORDS + (xr>>1).
  - If LINE_WORDS is odd, the last pixel is dropped.
- Line end (captured line, xr == LINE_WORDS-1), effective one cycle later:
  - slot increments modulo RING_LINES (RING_LINES-1 wraps to 0).
  - Captured-line count increments, saturating at TRIGGER_LINE.
- starttrigger is a one-cycle pulse in the cycle after the count reaches TRIGGER_LINE.
  - At most one pulse per frame; re-armed only at frame start.
- Slot advances only on captured lines. Lines in the line-doubler gap neither write nor advance the slot.
- Frame start coinciding with a line end: frame start wins (slot=0, count=0).
- Reset released mid-frame: no wren and no trigger until the next (0,0).
- wren is never asserted outside the window or in WAIT_FRAME.

Test Plan:
1. Reset low, release at x=100,y=50 → wren stays 0 until the cycle after (0,0) is sampled. First write is wraddr=0 in the cycle after x=0,y=0.
2. Normal mode, x=5,y=3, R/G/B=0x12/0x34/0x56 → next cycle: wren=1, wraddr=1925, wrdata=0x123456.
3. Normal mode, full frame → starttrigger is high for exactly one cycle, the cycle after the x=639,y=4 write is registered. No second pulse before the next (0,0).
4. Ring wrap, y=32, x=7 → slot=0, wraddr=7. At y=31, x=639 → wraddr=20479.
5. hdiv2=1 latched, y=0: x=0 R=0x10, x=1 R=0x21 → single write, wraddr=0, R=0x18. No wren for x=0.
6. line_doubler=1 → y=239 writes slot 15; y=240..262 give no wren; y=263 writes slot 16. Toggling line_doubler at y=100 changes nothing until the next frame.
